gpio_input_filter: RTL and testbench

//  Per-pin input conditioning stage directly upstream of the GPIO edge/interrupt detection logic.

---
 rtl/gpio_input_filter.sv | 87 ++++++++
 tb/tb_gpio_input_filter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_filter.sv
// Per-pin GPIO input conditioning: pad synchroniser, shared sample prescaler and
// optional debounce that flips io_out only after flen consecutive stable ticks.
module gpio_input_filter #(
  parameter int unsigned PINS        = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PINS-1:0]        pad_in,
  input  logic [PINS-1:0]        fen,
  input  logic [CNT_WIDTH-1:0]   flen,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic [PINS-1:0]        io_sync,
  output logic [PINS-1:0]        io_out,
  output logic                   tick
);

  localparam int unsigned CNT_EXT_W = CNT_WIDTH + 1;

  logic [PINS-1:0]        sync_q [SYNC_STAGES];
  logic [PRESC_WIDTH-1:0] pcnt;
  logic                   flen_zero;

  assign flen_zero = (flen == '0);

  // Synchroniser chain; the last stage is the registered io_sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign io_sync = sync_q[SYNC_STAGES-1];

  // Shared prescaler; a lowered presc below pcnt wraps on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt >= presc) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + PRESC_WIDTH'(1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(PINS); i++) begin : g_pin
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_EXT_W-1:0] cnt_inc;
    logic                 out_q;
    logic                 mismatch;
    logic                 bypass;

    assign cnt_inc  = {1'b0, cnt} + CNT_EXT_W'(1);
    assign mismatch = io_sync[i] ^ out_q;
    assign bypass   = !fen[i] || flen_zero;
    assign io_out[i] = out_q;

    // Stability counter: any reversion clears progress, flip once flen ticks seen
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        out_q <= 1'b0;
      end else if (bypass) begin
        cnt   <= '0;
        out_q <= io_sync[i];
      end else if (!mismatch) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt_inc >= {1'b0, flen}) begin
          cnt   <= '0;
          out_q <= ~out_q;
        end else if (cnt != '1) begin
          cnt <= cnt_inc[CNT_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed and randomised checks of gpio_input_filter against a cycle-level reference.
module tb_gpio_input_filter;

  localparam int NP = 32;

  logic          clk;
  logic          rst_n;
  logic [31:0]   pad_in;
  logic [31:0]   fen;
  logic [7:0]    flen;
  logic [15:0]   presc;
  logic [31:0]   io_sync;
  logic [31:0]   io_out;
  logic          tick;

  int total;
  int bad;

  // reference state
  bit [31:0] m_s0;
  bit [31:0] m_sync;
  bit [31:0] m_out;
  int        m_run [NP];
  int        m_pcnt;
  bit        m_tick;

  gpio_input_filter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_in  (pad_in),
    .fen     (fen),
    .flen    (flen),
    .presc   (presc),
    .io_sync (io_sync),
    .io_out  (io_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("io_sync", io_sync, m_sync);
    chk("io_out", io_out, m_out);
    chk("tick", {31'd0, tick}, {31'd0, m_tick});
  endtask

  task automatic model_reset();
    m_s0 = '0; m_sync = '0; m_out = '0; m_pcnt = 0; m_tick = 1'b0;
    for (int i = 0; i < NP; i++) m_run[i] = 0;
  endtask

  // Advance one clock: the pin holds its old value until it has been seen on
  // flen consecutive sample ticks with the new value.
  task automatic step();
    bit [31:0] n_out;
    int        n_run [NP];
    int        fl;
    bit        n_tick;
    int        n_pcnt;
    fl     = int'(flen);
    n_tick = (m_pcnt >= int'(presc));
    n_pcnt = n_tick ? 0 : m_pcnt + 1;
    n_out  = m_out;
    for (int i = 0; i < NP; i++) begin
      n_run[i] = m_run[i];
      if (!fen[i] || fl == 0) begin
        n_out[i] = m_sync[i];
        n_run[i] = 0;
      end else if (m_sync[i] == m_out[i]) begin
        n_run[i] = 0;
      end else if (m_tick) begin
        if (m_run[i] + 1 >= fl) begin
          n_out[i] = ~m_out[i];
          n_run[i] = 0;
        end else begin
          n_run[i] = (m_run[i] + 1 > 255) ? 255 : m_run[i] + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_sync = m_s0;
      m_s0   = pad_in;
      m_out  = n_out;
      m_pcnt = n_pcnt;
      m_tick = n_tick;
      for (int i = 0; i < NP; i++) m_run[i] = n_run[i];
    end
    chk_model();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_io_out", io_out, 32'd0);
    chk("rst_io_sync", io_sync, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    pad_in = '0;
    fen    = '0;
    flen   = '0;
    presc  = '0;
    model_reset();
    #2;
    chk("por_io_out", io_out, 32'd0);
    chk("por_io_sync", io_sync, 32'd0);
    chk("por_tick", {31'd0, tick}, 32'd0);
    #2;
    rst_n = 1'b1;
    steps(3);

    // bypass latency
    pad_in[3] = 1'b1;
    steps(2);
    chk("byp_sync3", {31'd0, io_sync[3]}, 32'd1);
    chk("byp_out3_early", {31'd0, io_out[3]}, 32'd0);
    step();
    chk("byp_out3", {31'd0, io_out[3]}, 32'd1);

    // glitch rejection
    fen  = '1;
    flen = 8'd4;
    steps(4);
    pad_in[0] = 1'b1;
    steps(3);
    pad_in[0] = 1'b0;
    steps(8);
    chk("glitch_out0", {31'd0, io_out[0]}, 32'd0);

    // accept after exactly SYNC_STAGES+flen edges
    pad_in[0] = 1'b1;
    steps(5);
    chk("acc_out0_early", {31'd0, io_out[0]}, 32'd0);
    step();
    chk("acc_out0", {31'd0, io_out[0]}, 32'd1);

    // prescaled sampling
    presc = 16'd9;
    flen  = 8'd3;
    steps(30);
    pad_in[5] = 1'b1;
    steps(45);
    chk("presc_out5", {31'd0, io_out[5]}, 32'd1);

    // reset in the middle of a qualification
    presc = 16'd0;
    flen  = 8'd8;
    steps(3);
    pad_in[7] = 1'b1;
    steps(7);
    apply_reset();
    steps(2);
    rst_n = 1'b1;
    steps(8);
    chk("rst_noflip7", {31'd0, io_out[7]}, 32'd0);
    steps(12);
    chk("rst_flip7", {31'd0, io_out[7]}, 32'd1);

    // lowering flen below progress flips on the next mismatching tick
    flen = 8'd10;
    pad_in[2] = 1'b1;
    steps(8);
    chk("flen_hold2", {31'd0, io_out[2]}, 32'd0);
    flen = 8'd3;
    step();
    chk("flen_flip2", {31'd0, io_out[2]}, 32'd1);
    flen = 8'd0;
    pad_in[2] = 1'b0;
    steps(2);
    chk("flen0_out2_early", {31'd0, io_out[2]}, 32'd1);
    step();
    chk("flen0_out2", {31'd0, io_out[2]}, 32'd0);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        fen   = $urandom;
        flen  = 8'($urandom_range(0, 6));
        presc = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) pad_in[$urandom_range(0, NP-1)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) pad_in = $urandom;
      if ($urandom_range(0, 60) == 0) presc = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) fen[$urandom_range(0, NP-1)] ^= 1'b1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 700) == 0) apply_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
